// File: rtl/ws2812_pixel_streamer_if.sv
// rtl/ws2812_pixel_streamer_if.sv - pixel stream handshake between host and streamer
interface ws2812_pixel_streamer_if #(
    parameter int BITS_PER_PIXEL = 24
) ();
    logic [BITS_PER_PIXEL-1:0] pixel_data;
    logic                      pixel_valid;
    logic                      pixel_last;
    logic                      pixel_ready;

    modport master (
        output pixel_data,
        output pixel_valid,
        output pixel_last,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  pixel_last,
        output pixel_ready
    );
endinterface

// File: rtl/ws2812_pixel_streamer.sv
// rtl/ws2812_pixel_streamer.sv - serialises pixel words MSB-first for the WS2812 RZ encoder
module ws2812_pixel_streamer #(
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ws2812_pixel_streamer_if.slave pix,
    input  logic                   cmd_request,
    input  logic                   data_request,
    output logic                   databit,
    output logic [1:0]             command,
    output logic                   busy,
    output logic                   underrun
);
    localparam int CW = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [CW-1:0] FULL = CW'(BITS_PER_PIXEL);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_TX    = 2'b01,
        CMD_RESET = 2'b10
    } cmd_e;

    logic [BITS_PER_PIXEL-1:0] hold;
    logic                      hold_valid;
    logic                      hold_last;
    logic [BITS_PER_PIXEL-1:0] sr;
    logic                      sr_last;
    logic [CW-1:0]             bit_cnt;
    logic                      reset_pending;
    logic                      consume_q;
    logic                      in_frame;

    cmd_e cmd;
    logic accept;
    logic load;
    logic tx_take;
    logic rst_take;

    always_comb begin
        cmd = CMD_IDLE;
        if (reset_pending) begin
            cmd = CMD_RESET;
        end else if (bit_cnt != '0) begin
            cmd = CMD_TX;
        end
    end

    assign accept   = pix.pixel_valid && !hold_valid;
    assign load     = (bit_cnt == '0) && hold_valid;
    // A request overlapping an in-flight consume cannot come from the encoder; drop it.
    assign tx_take  = (cmd_request || data_request) && (cmd == CMD_TX) && !consume_q;
    assign rst_take = cmd_request && (cmd == CMD_RESET) && !consume_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold          <= '0;
            hold_valid    <= 1'b0;
            hold_last     <= 1'b0;
            sr            <= '0;
            sr_last       <= 1'b0;
            bit_cnt       <= '0;
            reset_pending <= 1'b0;
            consume_q     <= 1'b0;
            in_frame      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun  <= data_request && (cmd == CMD_IDLE) && in_frame;
            consume_q <= tx_take;

            if (accept) begin
                hold       <= pix.pixel_data;
                hold_last  <= pix.pixel_last;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            // databit stays put for the cycle the encoder samples it; shift at its end.
            if (load) begin
                sr       <= hold;
                sr_last  <= hold_last;
                bit_cnt  <= FULL;
                in_frame <= !hold_last;
            end else if (consume_q) begin
                sr      <= sr << 1;
                bit_cnt <= bit_cnt - ONE;
                if (bit_cnt == ONE && sr_last) begin
                    reset_pending <= 1'b1;
                end
            end

            if (rst_take) begin
                reset_pending <= 1'b0;
            end
        end
    end

    assign pix.pixel_ready = !hold_valid;
    assign databit         = sr[BITS_PER_PIXEL-1];
    assign command         = cmd;
    assign busy            = (bit_cnt != '0) || hold_valid || reset_pending || consume_q;
endmodule
